// File: rtl/rhythm_game_ctrl.sv
// Rhythm game sequencer: button debounce, song select, play/pause/abort, scroll steps.
// Optional AUTO_ADVANCE_EN: after a song ends, wait 16 tick wraps then play the next one.
module rhythm_game_ctrl #(
  parameter int TICK_DIV     = 25000,
  parameter int DEBOUNCE_CYC = 16,
  parameter int SONG_CNT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bottom,
  input  logic       finish,
  output logic [1:0] song,
  output logic       load,
  output logic       step,
  output logic       playing,
  output logic       blank,
  output logic [2:0] state
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [1:0]    SONG_MAX = 2'(SONG_CNT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  logic [1:0]    sync1, sync2, level, press;
  logic [DW-1:0] cnt [2];

  // Level flips only after DEBOUNCE_CYC consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      level  <= '0;
      press  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= bottom;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_MAX) begin
          cnt[i]   <= '0;
          level[i] <= sync2[i];
          press[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic sel, start;
  assign sel   = press[0];
  assign start = press[1];

  state_t        state_q, state_n;
  logic [1:0]    song_n, song_nx;
  logic [TW-1:0] tick_q, tick_n, tick_inc;
  logic          tick_wrap, step_n;

`ifdef AUTO_ADVANCE_EN
  logic [3:0] wrap_q, wrap_n;
`endif

  always_comb begin
    state_n   = state_q;
    song_n    = song;
    tick_n    = tick_q;
    step_n    = 1'b0;
    tick_wrap = (tick_q == TICK_MAX);
    tick_inc  = tick_wrap ? '0 : tick_q + 1'b1;
    song_nx   = (song == SONG_MAX) ? 2'd0 : song + 2'd1;
`ifdef AUTO_ADVANCE_EN
    wrap_n    = wrap_q;
`endif
    case (state_q)
      IDLE: begin
        tick_n = '0;
        if (start)    state_n = LOAD;
        else if (sel) song_n  = song_nx;
      end
      LOAD: begin
        tick_n  = '0;
        state_n = PLAY;
      end
      PLAY: begin
        if (finish) begin
          state_n = DONE;
          tick_n  = '0;
        end else if (start) begin
          state_n = PAUSE;
        end else begin
          tick_n = tick_inc;
          step_n = tick_wrap;
        end
      end
      PAUSE: begin
        if (sel)        state_n = IDLE;
        else if (start) state_n = PLAY;
      end
      DONE: begin
        if (sel || start) begin
          state_n = IDLE;
        end
`ifdef AUTO_ADVANCE_EN
        else begin
          tick_n = tick_inc;
          if (tick_wrap) begin
            wrap_n = wrap_q + 4'd1;
            if (wrap_q == 4'hf) begin
              state_n = LOAD;
              song_n  = song_nx;
            end
          end
        end
`endif
      end
      default: begin
        state_n = IDLE;
        tick_n  = '0;
      end
    endcase
`ifdef AUTO_ADVANCE_EN
    if (state_q != DONE) wrap_n = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      song    <= 2'd0;
      tick_q  <= '0;
      load    <= 1'b0;
      step    <= 1'b0;
      playing <= 1'b0;
      blank   <= 1'b1;
    end else begin
      state_q <= state_n;
      song    <= song_n;
      tick_q  <= tick_n;
      load    <= (state_n == LOAD);
      step    <= step_n;
      playing <= (state_n == PLAY);
      blank   <= (state_n == IDLE) || (state_n == LOAD);
    end
  end

`ifdef AUTO_ADVANCE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_q <= '0;
    else     wrap_q <= wrap_n;
  end
`endif

  assign state = state_q;

endmodule

// File: tb/tb_rhythm_game_ctrl.sv
// Directed bench for rhythm_game_ctrl with scoreboard queues for song and step timing.
// Define AUTO_ADVANCE_EN to also exercise the auto-advance path.
module tb_rhythm_game_ctrl;

  localparam int TD = 4;
  localparam int DB = 4;
  localparam int SC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] bottom = 2'b00;
  logic       finish = 1'b0;
  logic [1:0] song;
  logic       load, step, playing, blank;
  logic [2:0] state;

  rhythm_game_ctrl #(
    .TICK_DIV(TD),
    .DEBOUNCE_CYC(DB),
    .SONG_CNT(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bottom(bottom),
    .finish(finish),
    .song(song),
    .load(load),
    .step(step),
    .playing(playing),
    .blank(blank),
    .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int ncyc = 0;
  int exp_song_q[$];
  int exp_step_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input int b);
    bottom[b] = 1'b1;
    cycles(DB + 5);
    bottom[b] = 1'b0;
    cycles(DB + 5);
  endtask

  task automatic wait_state(input string tag, input int s, input int bound,
                            output int at);
    int k;
    k = 0;
    while (32'(state) != s && k < bound) begin
      cyc();
      k++;
    end
    at = ncyc;
    chk(tag, 32'(state), s);
  endtask

  task automatic wait_step(input string tag, input int bound);
    int k;
    int e;
    k = 0;
    cyc();
    while (step !== 1'b1 && k < bound) begin
      cyc();
      k++;
    end
    e = (exp_step_q.size() > 0) ? exp_step_q.pop_front() : -1;
    chk(tag, ncyc, e);
  endtask

  initial begin
    int t, r, k, c0, d, n;
    int seq [4];
    seq = '{1, 2, 0, 1};

    cycles(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_blank", 32'(blank), 1);
    chk("rst_song", 32'(song), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_playing", 32'(playing), 0);
    rst = 1'b0;
    cycles(2);

    for (int i = 0; i < 4; i++) begin
      exp_song_q.push_back(seq[i]);
      press(0);
      chk("sel_song", 32'(song), exp_song_q.pop_front());
    end

    exp_song_q.push_back(1);
    bottom[0] = 1'b1;
    cycles(2);
    bottom[0] = 1'b0;
    cycles(12);
    chk("glitch_song", 32'(song), exp_song_q.pop_front());
    chk("glitch_state", 32'(state), 0);

    bottom[1] = 1'b1;
    wait_state("load_state", 1, 20, t);
    chk("load_pulse", 32'(load), 1);
    chk("load_no_step", 32'(step), 0);
    chk("load_blank", 32'(blank), 1);
    cyc();
    chk("play_state", 32'(state), 2);
    chk("load_once", 32'(load), 0);
    chk("play_playing", 32'(playing), 1);
    chk("play_blank", 32'(blank), 0);
    c0 = ncyc;
    bottom[1] = 1'b0;
    for (int i = 1; i <= 4; i++) exp_step_q.push_back(c0 + 4 * i);
    wait_step("step1", 10);
    wait_step("step2", 10);
    wait_step("step3", 10);
    bottom[1] = 1'b1;
    wait_step("step4", 10);
    wait_state("pause_state", 3, 10, t);
    chk("pause_at", t, c0 + 19);
    bottom[1] = 1'b0;
    n = 0;
    repeat (12) begin
      cyc();
      if (step === 1'b1) n++;
    end
    chk("pause_no_step", n, 0);
    chk("pause_blank", 32'(blank), 0);
    chk("pause_playing", 32'(playing), 0);

    k = ncyc;
    bottom[1] = 1'b1;
    wait_state("resume_state", 2, 20, r);
    chk("resume_at", r, k + 7);
    bottom[1] = 1'b0;
    exp_step_q.push_back(r + 2);
    exp_step_q.push_back(r + 6);
    wait_step("resume_step1", 10);
    wait_step("resume_step2", 10);

    bottom[1] = 1'b1;
    wait_state("pause2_state", 3, 20, t);
    bottom[1] = 1'b0;
    cycles(8);
    bottom[0] = 1'b1;
    wait_state("abort_idle", 0, 20, t);
    chk("abort_blank", 32'(blank), 1);
    chk("abort_song", 32'(song), 1);
    bottom[0] = 1'b0;
    cycles(8);

    finish = 1'b1;
    cycles(3);
    chk("idle_finish", 32'(state), 0);
    finish = 1'b0;

    bottom[1] = 1'b1;
    wait_state("play2_state", 2, 20, t);
    bottom[1] = 1'b0;
    cycles(8);
    bottom[1] = 1'b1;
    cycles(6);
    finish = 1'b1;
    cyc();
    chk("finish_prio", 32'(state), 4);
    chk("done_playing", 32'(playing), 0);
    chk("done_blank", 32'(blank), 0);
    finish = 1'b0;
    bottom[1] = 1'b0;
    n = 0;
    repeat (8) begin
      cyc();
      if (step === 1'b1) n++;
    end
    chk("done_no_step", n, 0);
    chk("done_hold", 32'(state), 4);
    bottom[0] = 1'b1;
    wait_state("done_idle", 0, 20, t);
    bottom[0] = 1'b0;
    cycles(8);

    bottom[1] = 1'b1;
    wait_state("play3_state", 2, 20, t);
    bottom[1] = 1'b0;
    cycles(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_blank", 32'(blank), 1);
    chk("arst_playing", 32'(playing), 0);
    chk("arst_song", 32'(song), 0);
    chk("arst_step", 32'(step), 0);
    cyc();
    rst = 1'b0;
    n = 0;
    repeat (12) begin
      cyc();
      if (load === 1'b1) n++;
    end
    chk("arst_no_load", n, 0);

`ifdef AUTO_ADVANCE_EN
    exp_song_q.push_back(1);
    exp_song_q.push_back(2);
    press(0);
    chk("aa_sel1", 32'(song), exp_song_q.pop_front());
    press(0);
    chk("aa_sel2", 32'(song), exp_song_q.pop_front());
    bottom[1] = 1'b1;
    wait_state("aa_play", 2, 20, t);
    bottom[1] = 1'b0;
    cycles(8);
    finish = 1'b1;
    cyc();
    chk("aa_done", 32'(state), 4);
    d = ncyc;
    finish = 1'b0;
    k = 0;
    while (load !== 1'b1 && k < 80) begin
      cyc();
      k++;
    end
    chk("aa_load_at", ncyc, d + 64);
    chk("aa_song", 32'(song), 0);
    cyc();
    chk("aa_play2", 32'(state), 2);
    chk("aa_load_once", 32'(load), 0);
    cycles(3);
    finish = 1'b1;
    cyc();
    chk("aa_done2", 32'(state), 4);
    finish = 1'b0;
    cycles(10);
    bottom[0] = 1'b1;
    wait_state("aa_cancel", 0, 20, t);
    bottom[0] = 1'b0;
    n = 0;
    repeat (80) begin
      cyc();
      if (load === 1'b1) n++;
    end
    chk("aa_no_load", n, 0);
    chk("aa_song_kept", 32'(song), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
